// File: rtl/dunit_dump_tx_pkg.sv
// Shared debug-unit definitions: frame start byte, dump FSM encoding, source select.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The RX command decoder and host tooling import this so that both ends agree on framing.
package dunit_dump_tx_pkg;

   // First byte of every dump frame. Host tooling resynchronises on it.
   localparam logic [7:0] DUMP_HDR_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_WAIT_RD = 3'd2,
      ST_SEND    = 3'd3,
      ST_NEXT    = 3'd4,
      ST_CKSUM   = 3'd5,
      ST_DONE    = 3'd6
   } dump_state_t;

   // Selects which array o_addr indexes while dumping.
   typedef enum logic {
      SRC_REG = 1'b0,
      SRC_MEM = 1'b1
   } dump_src_t;

endpackage

// File: rtl/dunit_dump_tx_if.sv
// Debug read bus plus UART TX FIFO write port, as seen by the dump unit.
// Latency: n/a (wires only).
// Backpressure: i_tx_full gates o_tx_wr in the same cycle.
// master: dump unit (drives address, FIFO data and strobe).
// slave : register file / data memory / TX FIFO side.
interface dunit_dump_tx_if #(
   parameter int NB_REG  = 32,
   parameter int NB_ADDR = 32
);
   logic [7:0]         o_tx_data;
   logic               o_tx_wr;
   logic               i_tx_full;
   logic [NB_ADDR-1:0] o_addr;
   logic [NB_REG-1:0]  i_reg_data;
   logic [NB_REG-1:0]  i_mem_data;

   modport master (
      output o_tx_data, o_tx_wr, o_addr,
      input  i_tx_full, i_reg_data, i_mem_data
   );

   modport slave (
      input  o_tx_data, o_tx_wr, o_addr,
      output i_tx_full, i_reg_data, i_mem_data
   );
endinterface

// File: rtl/dunit_word_serializer.sv
// Splits one latched word into bytes, LSB first, and keeps a running XOR of the bytes sent.
// Latency: byte 0 is on o_byte the cycle after i_load; one byte per cycle in which i_send & !i_full.
// Backpressure: i_full freezes the shift register, byte index and checksum.
// Ports: i_clear zeroes the checksum, i_load captures i_word, o_last marks the final byte being written.
module dunit_word_serializer #(
   parameter int NB_REG = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [NB_REG-1:0] i_word,
   input  logic              i_send,
   input  logic              i_full,
   output logic [7:0]        o_byte,
   output logic              o_last,
   output logic [7:0]        o_cksum
);
   localparam int NB_BYTES = NB_REG / 8;
   localparam int BIW      = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

   logic [NB_REG-1:0] shreg;
   logic [BIW-1:0]    byte_idx;
   logic              fire;

   // A byte leaves only when the FIFO can take it, so this is also the write strobe.
   assign fire   = i_send & ~i_full;
   assign o_byte = shreg[7:0];
   assign o_last = fire && (byte_idx == BIW'(NB_BYTES - 1));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         shreg    <= '0;
         byte_idx <= '0;
         o_cksum  <= '0;
      end else begin
         if (i_clear)
            o_cksum <= '0;
         else if (fire)
            o_cksum <= o_cksum ^ shreg[7:0];

         if (i_load) begin
            shreg    <= i_word;
            byte_idx <= '0;
         end else if (fire) begin
            shreg    <= shreg >> 8;
            byte_idx <= o_last ? '0 : byte_idx + BIW'(1);
         end
      end
   end
endmodule

// File: rtl/dunit_dump_tx.sv
// Dumps the register file and then the first N_MEM_WORDS data-memory words into the UART TX FIFO.
// Frame: HDR_BYTE, the words LSB first, then an XOR checksum of the word bytes.
// Latency: o_done 1 + N_REGS*6 + N_MEM_WORDS*(6+RD_LAT) + 2 cycles after i_start when the FIFO never fills.
// Backpressure: i_tx_full holds the FSM, data and counters; o_tx_wr is never raised while full.
// Ports: i_clk/i_reset (async, active low), i_start (one-cycle pulse, ignored while busy),
//        bus (master: read address, read data, FIFO write port), o_busy, o_done (one-cycle pulse).
module dunit_dump_tx
   import dunit_dump_tx_pkg::*;
#(
   parameter int         NB_REG      = 32,
   parameter int         N_REGS      = 32,
   parameter int         N_MEM_WORDS = 32,
   parameter int         NB_ADDR     = 32,
   parameter int         RD_LAT      = 1,
   parameter logic [7:0] HDR_BYTE    = DUMP_HDR_BYTE
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   dunit_dump_tx_if.master       bus,
   output logic                  o_busy,
   output logic                  o_done
);
   localparam int WCW = $clog2(RD_LAT + 2);

   dump_state_t        state, state_nxt;
   dump_src_t          src, src_nxt;
   logic [NB_ADDR-1:0] addr_nxt;
   logic [WCW-1:0]     wcnt, wcnt_nxt;
   logic               rd_ready;
   logic               ser_clear, ser_load, ser_send, ser_last;
   logic [7:0]         ser_byte, ser_cksum;

   // Register reads are combinational; memory reads settle RD_LAT cycles after o_addr moved.
   // wcnt restarts at 0 on every address change, so RD_LAT=0 latches in the first WAIT_RD cycle.
   assign rd_ready = (src == SRC_REG) ? (wcnt == '0) : (wcnt == WCW'(RD_LAT));

   dunit_word_serializer #(.NB_REG(NB_REG)) u_ser (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (ser_clear),
      .i_load  (ser_load),
      .i_word  ((src == SRC_REG) ? bus.i_reg_data : bus.i_mem_data),
      .i_send  (ser_send),
      .i_full  (bus.i_tx_full),
      .o_byte  (ser_byte),
      .o_last  (ser_last),
      .o_cksum (ser_cksum)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state      <= ST_IDLE;
         src        <= SRC_REG;
         bus.o_addr <= '0;
         wcnt       <= '0;
      end else begin
         state      <= state_nxt;
         src        <= src_nxt;
         bus.o_addr <= addr_nxt;
         wcnt       <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      src_nxt       = src;
      addr_nxt      = bus.o_addr;
      wcnt_nxt      = wcnt;
      ser_clear     = 1'b0;
      ser_load      = 1'b0;
      ser_send      = 1'b0;
      bus.o_tx_wr   = 1'b0;
      bus.o_tx_data = '0;
      o_busy        = 1'b1;
      o_done        = 1'b0;

      case (state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (i_start) begin
               state_nxt = ST_HDR;
               src_nxt   = SRC_REG;
               addr_nxt  = '0;
               ser_clear = 1'b1;
            end
         end
         ST_HDR: begin
            bus.o_tx_data = HDR_BYTE;
            if (!bus.i_tx_full) begin
               bus.o_tx_wr = 1'b1;
               wcnt_nxt    = '0;
               state_nxt   = ST_WAIT_RD;
            end
         end
         ST_WAIT_RD: begin
            if (rd_ready) begin
               ser_load  = 1'b1;
               state_nxt = ST_SEND;
            end else begin
               wcnt_nxt = wcnt + WCW'(1);
            end
         end
         ST_SEND: begin
            ser_send      = 1'b1;
            bus.o_tx_data = ser_byte;
            bus.o_tx_wr   = ~bus.i_tx_full;
            if (ser_last)
               state_nxt = ST_NEXT;
         end
         ST_NEXT: begin
            wcnt_nxt = '0;
            if (src == SRC_REG && bus.o_addr == NB_ADDR'(N_REGS - 1)) begin
               if (N_MEM_WORDS == 0) begin
                  state_nxt = ST_CKSUM;
               end else begin
                  src_nxt   = SRC_MEM;
                  addr_nxt  = '0;
                  state_nxt = ST_WAIT_RD;
               end
            end else if (src == SRC_MEM && bus.o_addr == NB_ADDR'(N_MEM_WORDS - 1)) begin
               state_nxt = ST_CKSUM;
            end else begin
               addr_nxt  = bus.o_addr + NB_ADDR'(1);
               state_nxt = ST_WAIT_RD;
            end
         end
         ST_CKSUM: begin
            bus.o_tx_data = ser_cksum;
            if (!bus.i_tx_full) begin
               bus.o_tx_wr = 1'b1;
               state_nxt   = ST_DONE;
            end
         end
         ST_DONE: begin
            // i_start is not looked at here, so a request in this cycle is dropped.
            o_busy    = 1'b0;
            o_done    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_dunit_dump_tx.sv
// Bench for dunit_dump_tx: three instances (full default dump, RD_LAT=2 with poisoned
// memory data, single register with no memory). Expected bytes are queued at start time
// and popped by a negedge monitor whenever an instance strobes o_tx_wr.
module tb_dunit_dump_tx;
   logic clk = 1'b0;
   logic rst_n;
   logic start_a, start_b, start_c;
   logic busy_a, busy_b, busy_c;
   logic done_a, done_b, done_c;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dunit_dump_tx_if #(.NB_REG(32), .NB_ADDR(32)) bus_a ();
   dunit_dump_tx_if #(.NB_REG(32), .NB_ADDR(32)) bus_b ();
   dunit_dump_tx_if #(.NB_REG(32), .NB_ADDR(32)) bus_c ();

   dunit_dump_tx #(.NB_REG(32), .N_REGS(32), .N_MEM_WORDS(32), .NB_ADDR(32),
                   .RD_LAT(1), .HDR_BYTE(8'hA5)) dut_a (
      .i_clk(clk), .i_reset(rst_n), .i_start(start_a), .bus(bus_a),
      .o_busy(busy_a), .o_done(done_a));

   dunit_dump_tx #(.NB_REG(32), .N_REGS(2), .N_MEM_WORDS(3), .NB_ADDR(32),
                   .RD_LAT(2), .HDR_BYTE(8'hA5)) dut_b (
      .i_clk(clk), .i_reset(rst_n), .i_start(start_b), .bus(bus_b),
      .o_busy(busy_b), .o_done(done_b));

   dunit_dump_tx #(.NB_REG(32), .N_REGS(1), .N_MEM_WORDS(0), .NB_ADDR(32),
                   .RD_LAT(1), .HDR_BYTE(8'hA5)) dut_c (
      .i_clk(clk), .i_reset(rst_n), .i_start(start_c), .bus(bus_c),
      .o_busy(busy_c), .o_done(done_c));

   // ---------------- memory models ----------------
   logic [31:0] mem_a_q;
   assign bus_a.i_reg_data = 32'h0102_0300 + bus_a.o_addr;
   always @(posedge clk) mem_a_q <= 32'hA000_0000 + bus_a.o_addr;
   assign bus_a.i_mem_data = mem_a_q;

   // RD_LAT=2: data is a poison word until two edges after the address last moved.
   logic [31:0] last_b = '0;
   int          age_b  = 0;
   always @(posedge clk) begin
      if (bus_b.o_addr != last_b) begin
         last_b <= bus_b.o_addr;
         age_b  <= 1;
      end else if (age_b < 2) begin
         age_b <= age_b + 1;
      end
   end
   assign bus_b.i_reg_data = 32'h0102_0300 + bus_b.o_addr;
   assign bus_b.i_mem_data = (bus_b.o_addr == last_b && age_b >= 2)
                             ? 32'hA000_0000 + bus_b.o_addr : 32'hBAD0_BAD0;

   assign bus_c.i_reg_data = 32'hDEAD_BEEF;
   assign bus_c.i_mem_data = 32'h0000_0000;

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q [3][$];
   int sent [3];
   int done_cnt [3];
   int done_cyc [3];
   int n_vec = 0;
   int n_err = 0;
   int st_cyc, s0, s1, d0;

   task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (dut%0d): actual %h, required %h", name, i, act, exp);
      end
   endtask

   task automatic mon(input int i, input logic wr, input logic [7:0] dat, input logic full, input logic done);
      logic [7:0] e;
      if (wr) begin
         sent[i]++;
         check("wr_while_full", i, 32'(full), 32'h0);
         if (exp_q[i].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_wr (dut%0d): actual strobe with data %h, required none", i, dat);
         end else begin
            e = exp_q[i].pop_front();
            check("tx_byte", i, 32'(dat), 32'(e));
         end
      end
      if (done) begin
         done_cnt[i]++;
         done_cyc[i] = cyc;
         check("bytes_left_at_done", i, 32'(exp_q[i].size()), 32'h0);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, bus_a.o_tx_wr, bus_a.o_tx_data, bus_a.i_tx_full, done_a);
         mon(1, bus_b.o_tx_wr, bus_b.o_tx_data, bus_b.i_tx_full, done_b);
         mon(2, bus_c.o_tx_wr, bus_c.o_tx_data, bus_c.i_tx_full, done_c);
      end
   end

   // Header, nregs words from reg_base+k, nmem words from mem_base+k, XOR checksum.
   task automatic push_frame(input int i, input int nregs, input int nmem,
                             input logic [31:0] reg_base, input logic [31:0] mem_base);
      logic [7:0]  ck;
      logic [31:0] w;
      ck = 8'h00;
      exp_q[i].push_back(8'hA5);
      for (int k = 0; k < nregs + nmem; k++) begin
         w = (k < nregs) ? reg_base + 32'(k) : mem_base + 32'(k - nregs);
         for (int b = 0; b < 4; b++) begin
            exp_q[i].push_back(w[8*b +: 8]);
            ck ^= w[8*b +: 8];
         end
      end
      exp_q[i].push_back(ck);
   endtask

   task automatic pulse(input int i);
      @(posedge clk); #1;
      st_cyc = cyc;
      case (i)
         0: start_a = 1'b1;
         1: start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
   endtask

   task automatic wait_done(input int i, input int d_before, input int budget, input string name);
      int c = 0;
      while (done_cnt[i] == d_before && c < budget) begin
         @(posedge clk);
         c++;
      end
      check(name, i, 32'(done_cnt[i] - d_before), 32'h1);
   endtask

   task automatic wait_sent(input int i, input int n, input int budget, input string name);
      int c = 0;
      while (sent[i] < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      check(name, i, 32'(sent[i] >= n), 32'h1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tx_wr"},   0, 32'(bus_a.o_tx_wr), 32'h0);
      check({tag, "_tx_data"}, 0, 32'(bus_a.o_tx_data), 32'h0);
      check({tag, "_addr"},    0, bus_a.o_addr, 32'h0);
      check({tag, "_busy"},    0, 32'(busy_a), 32'h0);
      check({tag, "_done"},    0, 32'(done_a), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] hand_c [6];
      int left;
      bit burst_done;
      int c;

      hand_c = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      for (int i = 0; i < 3; i++) begin
         sent[i] = 0;
         done_cnt[i] = 0;
         done_cyc[i] = 0;
      end
      rst_n   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
      bus_a.i_tx_full = 1'b0;
      bus_b.i_tx_full = 1'b0;
      bus_c.i_tx_full = 1'b0;
      #1 rst_n = 1'b0;
      #2 check_idle_outputs("reset");
      #20 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Full default dump, no backpressure.
      push_frame(0, 32, 32, 32'h0102_0300, 32'hA000_0000);
      s0 = sent[0]; d0 = done_cnt[0];
      pulse(0);
      wait_done(0, d0, 1000, "nominal_done");
      check("nominal_latency", 0, 32'(done_cyc[0] - st_cyc), 32'd419);
      check("nominal_strobes", 0, 32'(sent[0] - s0), 32'd258);

      // One register, no memory: A5 EF BE AD DE 22.
      foreach (hand_c[k]) exp_q[2].push_back(hand_c[k]);
      s0 = sent[2]; d0 = done_cnt[2];
      pulse(2);
      wait_done(2, d0, 100, "edge_done");
      check("edge_latency", 2, 32'(done_cyc[2] - st_cyc), 32'd9);
      check("edge_strobes", 2, 32'(sent[2] - s0), 32'd6);

      // RD_LAT=2: 1 + 2*6 + 3*8 + 2 = 39 cycles, 22 bytes.
      push_frame(1, 2, 3, 32'h0102_0300, 32'hA000_0000);
      s0 = sent[1]; d0 = done_cnt[1];
      pulse(1);
      wait_done(1, d0, 200, "rdlat2_done");
      check("rdlat2_latency", 1, 32'(done_cyc[1] - st_cyc), 32'd39);
      check("rdlat2_strobes", 1, 32'(sent[1] - s0), 32'd22);

      // Random 50% full, plus a 200-cycle full burst during the register phase.
      push_frame(0, 32, 32, 32'h0102_0300, 32'hA000_0000);
      s0 = sent[0]; d0 = done_cnt[0];
      pulse(0);
      left = 0; burst_done = 1'b0; c = 0;
      while (done_cnt[0] == d0 && c < 6000) begin
         @(posedge clk); #1;
         c++;
         if (left > 0) begin
            bus_a.i_tx_full = 1'b1;
            left--;
         end else if (!burst_done && sent[0] - s0 >= 60) begin
            burst_done = 1'b1;
            left = 199;
            bus_a.i_tx_full = 1'b1;
         end else begin
            bus_a.i_tx_full = 1'($urandom_range(0, 1));
         end
      end
      bus_a.i_tx_full = 1'b0;
      check("bp_done", 0, 32'(done_cnt[0] - d0), 32'h1);
      check("bp_strobes", 0, 32'(sent[0] - s0), 32'd258);

      // Second start while busy must be ignored.
      push_frame(0, 32, 32, 32'h0102_0300, 32'hA000_0000);
      s0 = sent[0]; d0 = done_cnt[0];
      pulse(0);
      wait_sent(0, s0 + 40, 500, "restart_reach40");
      pulse(0);
      wait_done(0, d0, 1000, "restart_done");
      repeat (40) @(posedge clk);
      check("restart_done_count", 0, 32'(done_cnt[0] - d0), 32'h1);
      check("restart_strobes", 0, 32'(sent[0] - s0), 32'd258);

      // Asynchronous reset part-way through the frame.
      push_frame(0, 32, 32, 32'h0102_0300, 32'hA000_0000);
      s0 = sent[0];
      pulse(0);
      wait_sent(0, s0 + 100, 500, "abort_reach100");
      #3 rst_n = 1'b0;
      #1 check_idle_outputs("abort");
      exp_q[0].delete();
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      s1 = sent[0];
      repeat (30) @(posedge clk);
      check("abort_quiet_strobes", 0, 32'(sent[0] - s1), 32'h0);
      check("abort_quiet_busy", 0, 32'(busy_a), 32'h0);
      push_frame(0, 32, 32, 32'h0102_0300, 32'hA000_0000);
      s0 = sent[0]; d0 = done_cnt[0];
      pulse(0);
      wait_done(0, d0, 1000, "after_abort_done");
      check("after_abort_latency", 0, 32'(done_cyc[0] - st_cyc), 32'd419);
      check("after_abort_strobes", 0, 32'(sent[0] - s0), 32'd258);

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dunit_dump_tx.md
Name: dunit_dump_tx

Overview:
Transmit-side companion of the debug unit's program-load path. It reads back machine state over the shared debug address bus: all register-file entries first, then the first N_MEM_WORDS data-memory words. It frames those words as a byte stream and pushes it into the UART TX FIFO through a write/full handshake. It runs on the core clock, starts on a pulse from the debug command decoder, and reports completion with a one-cycle done pulse.

Parameters:
NB_REG, 32, data word width in bits (must be a multiple of 8)
N_REGS, 32, register-file entries dumped
N_MEM_WORDS, 32, data-memory words dumped
NB_ADDR, 32, width of the debug address bus
RD_LAT, 1, cycles from o_addr change to valid i_mem_data (register read is combinational)
HDR_BYTE, 8'hA5, frame start byte

Ports:
i_clk  in  1  core clock
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle dump request; ignored while o_busy
i_reg_data  in  NB_REG  register-file read data for o_addr
i_mem_data  in  NB_REG  data-memory read data for o_addr, valid RD_LAT cycles after o_addr
i_tx_full  in  1  UART TX FIFO full
o_tx_data  out  8  byte to FIFO
o_tx_wr  out  1  FIFO write strobe, one cycle per byte
o_addr  out  NB_ADDR  debug read address (register index or word index)
o_busy  out  1  dump in progress
o_done  out  1  one-cycle pulse after the checksum byte is written

Behaviour:
- Reset (i_reset=0, async): state IDLE; o_tx_data=0, o_tx_wr=0, o_addr=0, o_busy=0, o_done=0; word counter, byte index and checksum cleared. Reset mid-dump aborts silently. No byte is emitted after release until a new i_start.
- Frame: HDR_BYTE; then N_REGS words; then N_MEM_WORDS words; then checksum.
  - Words are sent as NB_REG/8 bytes, least-significant byte first.
  - Checksum = XOR of all word bytes; the header is excluded.
  - Default frame length: 1+128+128+1 = 258 bytes.
- Write rule: o_tx_wr=1 only in a cycle where i_tx_full=0, so every strobe is accepted. o_tx_data is valid with the strobe. While i_tx_full=1, the FSM holds state, data and counters.
- FSM states:
  - IDLE: on i_start -> HDR. Set o_busy=1, o_addr=0, src=REG, checksum=0.
  - HDR: write HDR_BYTE when !full -> WAIT_RD.
  - WAIT_RD: wait src==REG ? 0 : RD_LAT cycles after o_addr is stable. Latch the selected source into a shift register -> SEND. An RD_LAT=0 mem read latches in the first WAIT_RD cycle.
  - SEND: write the low byte when !full, XOR it into the checksum, shift right 8, increment the byte index. After the last byte -> NEXT.
  - NEXT:
    - If src==REG and o_addr==N_REGS-1: src=MEM, o_addr=0 -> WAIT_RD.
    - If src==MEM and o_addr==N_MEM_WORDS-1 -> CKSUM.
    - Otherwise o_addr+1 -> WAIT_RD.
  - CKSUM: write the checksum when !full -> DONE.
  - DONE: o_done=1 for one cycle, o_busy=0 -> IDLE.
- Throughput without backpressure:
  - 1 + N_REGS*(1+4+1) + N_MEM_WORDS*(1+RD_LAT+4+1) + 1 + 1 cycles from the i_start cycle to o_done.
  - Default: 1+192+224+1+1 = 419.
- i_start while busy is ignored, with no restart and no queuing. i_start in the DONE cycle is also ignored.
- o_addr changes only in IDLE->HDR and NEXT, and is stable through WAIT_RD/SEND.
- N_MEM_WORDS=0 is legal: NEXT goes REG -> CKSUM directly. N_REGS>=1 is required.
- i_tx_full stuck high stalls indefinitely; there is no timeout.

Decomposition:
- Shared debug package: HDR_BYTE, state encoding, and the src select constant (REG=0, MEM=1), so the RX command decoder and host tooling agree on framing.
- One sub-module is natural: dunit_word_serializer. It latches a word, emits bytes LSB-first under the !full handshake, accumulates the XOR, and pulses last. The top FSM owns addressing and frame sequencing.

Test Plan:
- Full dump, no backpressure: reg[k]=32'h0102_0300+k, mem[k]=32'hA000_0000+k, RD_LAT=1, pulse i_start.
  - Bytes: A5, 00 03 02 01, 01 03 02 01, ...; byte 129 = 00 (mem[0] LSB); byte 257 = XOR of all payload bytes.
  - 258 strobes; o_done at cycle 419.
- Backpressure: toggle i_tx_full randomly (50%), plus a 200-cycle high burst mid-register phase -> byte stream identical to the no-stall run, no duplicate or dropped strobes, and o_tx_wr never asserted with i_tx_full=1.
- Start during dump: second i_start pulse at byte 40 -> single 258-byte frame and one o_done pulse.
- Async reset mid-dump: i_reset low at byte 100 asynchronously -> all outputs 0 immediately. After release, with no start there are no strobes; a new i_start yields a complete, correct frame.
- Memory latency: RD_LAT=2 with a model whose mem data is X until 2 cycles after the address change -> no X on o_tx_data, and mem bytes are correct.
- Edge params: N_MEM_WORDS=0, N_REGS=1, reg[0]=32'hDEADBEEF -> frame A5 EF BE AD DE 22, with o_done after 6 strobes (checksum EF^BE^AD^DE = 22).
